// File: rtl/sensor_conditioner.sv
// Vehicle-loop sensor conditioner: turns the two raw, asynchronous loop
// detector inputs into clean occupancy levels for the traffic light controller.
// Each channel is synchronised, debounced on assertion and held on release.
// Optional feature macro: SENSOR_FAULT_EN builds the sticky implausible-queue
// flag (5th-position loop occupied while the 1st is not).

module sensor_conditioner_chan #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);

    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        ON_PEND  = 2'd1,
        ON       = 2'd2,
        OFF_PEND = 2'd3
    } state_t;

    logic             sync0_q;
    logic             sync1_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             d_q;

    // The count only ever climbs to the active threshold, so this never wraps.
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Two-flop synchroniser; only the second stage feeds the state machine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= raw_i;
            sync1_q <= sync0_q;
        end
    end

    // Debounce-on-assert / hold-on-release state machine with registered level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
            d_q     <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    if (sync1_q) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= ON;
                            cnt_q   <= '0;
                            d_q     <= 1'b1;
                        end else begin
                            state_q <= ON_PEND;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                ON_PEND: begin
                    if (sync1_q) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
                            state_q <= ON;
                            cnt_q   <= '0;
                            d_q     <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end else begin
                        state_q <= OFF;
                        cnt_q   <= '0;
                    end
                end
                ON: begin
                    if (!sync1_q) begin
                        if (HOLD_CYCLES == 1) begin
                            state_q <= OFF;
                            cnt_q   <= '0;
                            d_q     <= 1'b0;
                        end else begin
                            state_q <= OFF_PEND;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                OFF_PEND: begin
                    if (!sync1_q) begin
                        if (cnt_inc == CNT_W'(HOLD_CYCLES)) begin
                            state_q <= OFF;
                            cnt_q   <= '0;
                            d_q     <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end else begin
                        state_q <= ON;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= OFF;
                    cnt_q   <= '0;
                    d_q     <= 1'b0;
                end
            endcase
        end
    end

    assign level_o = d_q;

endmodule

module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int FAULT_CYCLES    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic loop_1th_raw,
    input  logic loop_5th_raw,
    input  logic fault_clr,
    output logic sensor_1th,
    output logic sensor_5th,
    output logic fault
);

    logic d1;
    logic d5;

    sensor_conditioner_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan_1th (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (loop_1th_raw),
        .level_o(d1)
    );

    sensor_conditioner_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan_5th (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (loop_5th_raw),
        .level_o(d5)
    );

    // Both terms are registered, so the qualification adds no latency; d5 keeps
    // tracking its loop even while the 1st position reads empty.
    assign sensor_1th = d1;
    assign sensor_5th = d5 & d1;

`ifdef SENSOR_FAULT_EN
    localparam int FCNT_W = $clog2(FAULT_CYCLES + 1);

    logic              cond;
    logic [FCNT_W-1:0] fcnt_q;
    logic [FCNT_W-1:0] fcnt_inc;
    logic              fault_q;

    assign cond     = d5 & ~d1;
    assign fcnt_inc = fcnt_q + FCNT_W'(1);

    // Sticky implausible-queue flag; the counter saturates at the threshold and
    // a clear pulse overrides a set landing on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt_q  <= '0;
            fault_q <= 1'b0;
        end else if (fault_clr) begin
            fcnt_q  <= '0;
            fault_q <= 1'b0;
        end else if (!cond) begin
            fcnt_q <= '0;
        end else if (fcnt_q != FCNT_W'(FAULT_CYCLES)) begin
            fcnt_q <= fcnt_inc;
            if (fcnt_inc == FCNT_W'(FAULT_CYCLES)) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign fault = fault_q;
`else
    localparam int unused_fault_cycles = FAULT_CYCLES;
    logic unused_fault_clr;

    assign unused_fault_clr = fault_clr;
    assign fault            = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed testbench for sensor_conditioner at default parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_sensor_conditioner;

`ifdef SENSOR_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic loop_1th_raw;
    logic loop_5th_raw;
    logic fault_clr;
    logic sensor_1th;
    logic sensor_5th;
    logic fault;

    int n_checks;
    int n_errors;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .FAULT_CYCLES   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .loop_1th_raw(loop_1th_raw),
        .loop_5th_raw(loop_5th_raw),
        .fault_clr   (fault_clr),
        .sensor_1th  (sensor_1th),
        .sensor_5th  (sensor_5th),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b0;
        loop_1th_raw = 1'b1;
        loop_5th_raw = 1'b1;
        fault_clr    = 1'b0;

        // Reset held with both loops occupied
        tick(3);
        check_eq("rst_s1", sensor_1th, 1'b0);
        check_eq("rst_s5", sensor_5th, 1'b0);
        check_eq("rst_fault", fault, 1'b0);

        // Release: rises exactly 6 edges later
        rst = 1'b1;
        tick(1);
        check_eq("rel_edge1_s1", sensor_1th, 1'b0);
        tick(4);
        check_eq("rel_edge5_s1", sensor_1th, 1'b0);
        tick(1);
        check_eq("rel_edge6_s1", sensor_1th, 1'b1);
        check_eq("rel_edge6_s5", sensor_5th, 1'b1);

        // Short low gap is bridged by the hold
        loop_1th_raw = 1'b0;
        tick(5);
        loop_1th_raw = 1'b1;
        tick(3);
        check_eq("gap_mid_s1", sensor_1th, 1'b1);
        tick(8);
        check_eq("gap_after_s1", sensor_1th, 1'b1);

        // Steady release: falls 10 edges after the fall
        loop_1th_raw = 1'b0;
        loop_5th_raw = 1'b0;
        tick(9);
        check_eq("fall_edge9_s1", sensor_1th, 1'b1);
        tick(1);
        check_eq("fall_edge10_s1", sensor_1th, 1'b0);
        check_eq("fall_edge10_s5", sensor_5th, 1'b0);
        tick(4);

        // Bounce: high 3, low 1, then held high
        loop_1th_raw = 1'b1;
        tick(3);
        loop_1th_raw = 1'b0;
        tick(1);
        loop_1th_raw = 1'b1;
        tick(3);
        check_eq("bounce_s1", sensor_1th, 1'b0);
        tick(2);
        check_eq("bounce_edge5_s1", sensor_1th, 1'b0);
        tick(1);
        check_eq("bounce_edge6_s1", sensor_1th, 1'b1);

        // Qualification: 5th alone is masked
        loop_1th_raw = 1'b0;
        tick(12);
        check_eq("qual_pre_s1", sensor_1th, 1'b0);
        loop_5th_raw = 1'b1;
        tick(8);
        check_eq("qual_5only_s5", sensor_5th, 1'b0);
        check_eq("qual_5only_s1", sensor_1th, 1'b0);
        loop_1th_raw = 1'b1;
        tick(5);
        check_eq("qual_edge5_s5", sensor_5th, 1'b0);
        tick(1);
        check_eq("qual_edge6_s1", sensor_1th, 1'b1);
        check_eq("qual_edge6_s5", sensor_5th, 1'b1);
        check_eq("qual_nofault", fault, 1'b0);

        // Fault: implausible condition from an all-empty start
        loop_1th_raw = 1'b0;
        loop_5th_raw = 1'b0;
        tick(12);
        loop_5th_raw = 1'b1;
        tick(21);
        check_eq("fault_edge21", fault, 1'b0);
        tick(1);
        check_eq("fault_edge22", fault, FAULT_EN);
        tick(3);
        check_eq("fault_sticky", fault, FAULT_EN);

        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check_eq("fault_clr", fault, 1'b0);
        tick(15);
        check_eq("fault_reset_15", fault, 1'b0);
        tick(1);
        check_eq("fault_reset_16", fault, FAULT_EN);

        // Clear coinciding with the set edge wins
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check_eq("fault_clr2", fault, 1'b0);
        tick(15);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check_eq("fault_clr_wins", fault, 1'b0);
        tick(15);
        check_eq("fault_after_tie_15", fault, 1'b0);
        tick(1);
        check_eq("fault_after_tie_16", fault, FAULT_EN);

        // Mid-hold reset discards the state immediately
        loop_1th_raw = 1'b1;
        loop_5th_raw = 1'b0;
        tick(12);
        check_eq("mid_pre_s1", sensor_1th, 1'b1);
        loop_1th_raw = 1'b0;
        tick(6);
        check_eq("mid_hold_s1", sensor_1th, 1'b1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_s1", sensor_1th, 1'b0);
        check_eq("mid_rst_s5", sensor_5th, 1'b0);
        check_eq("mid_rst_fault", fault, 1'b0);
        tick(2);
        rst = 1'b1;
        tick(12);
        check_eq("mid_after_s1", sensor_1th, 1'b0);
        check_eq("mid_after_s5", sensor_5th, 1'b0);
        check_eq("mid_after_fault", fault, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
